// File: rtl/dot_product_job_scheduler.sv
// Two-requester dot-product job scheduler: round-robin arbitration, package
// streaming to a shared engine, result capture with watchdog and length check.
module dot_product_job_scheduler #(
  parameter int ELEMENT_WIDTH = 32,
  parameter int NO_OF_UNITS   = 128,
  parameter int PKG_INTERVAL  = 2,
  parameter int TIMEOUT       = 1024
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     req0,
  input  logic                     req1,
  input  logic [31:0]              total0,
  input  logic [31:0]              total1,
  output logic                     grant0,
  output logic                     grant1,
  output logic [15:0]              pkg_addr,
  output logic                     eng_read_now,
  output logic [31:0]              eng_total,
  output logic                     eng_reset,
  input  logic                     eng_finish,
  input  logic [ELEMENT_WIDTH-1:0] eng_result,
  output logic [ELEMENT_WIDTH-1:0] result,
  output logic                     result_valid,
  output logic                     done_id,
  output logic                     err,
  output logic                     busy
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLEAR  = 3'd1,
    S_STREAM = 3'd2,
    S_WAIT   = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  localparam logic [31:0] UNITS   = 32'(NO_OF_UNITS);
  localparam logic [15:0] PH_LAST = 16'(PKG_INTERVAL - 1);
  localparam logic [31:0] WD_LAST = 32'(TIMEOUT - 1);

  state_t                   state_q, state_d;
  logic                     id_q, id_d;
  logic                     last_q, last_d;
  logic [31:0]              total_q, total_d;
  logic [15:0]              pkg_last_q, pkg_last_d;
  logic [15:0]              pkg_cnt_q, pkg_cnt_d;
  logic [15:0]              phase_q, phase_d;
  logic [31:0]              wdog_q, wdog_d;
  logic [ELEMENT_WIDTH-1:0] res_s;
  logic                     err_s;

  logic                     sel_s;
  logic [31:0]              sel_total_s;
  logic [31:0]              sel_npkg_s;
  logic                     sel_bad_s;
  logic                     active_s;

  logic                     grant0_q, grant0_d, grant1_q, grant1_d;
  logic [15:0]              pkg_addr_q, pkg_addr_d;
  logic                     eng_read_now_q, eng_read_now_d;
  logic [31:0]              eng_total_q, eng_total_d;
  logic                     eng_reset_q, eng_reset_d;
  logic [ELEMENT_WIDTH-1:0] result_q, result_d;
  logic                     result_valid_q, result_valid_d;
  logic                     done_id_q, done_id_d;
  logic                     err_q, err_d;
  logic                     busy_q, busy_d;

  // Arbitration: on a tie the requester not served last wins.
  always_comb begin
    sel_s       = (req0 & req1) ? ~last_q : req1;
    sel_total_s = sel_s ? total1 : total0;
    sel_npkg_s  = sel_total_s / UNITS;
    sel_bad_s   = (sel_total_s == 32'd0) || ((sel_total_s % UNITS) != 32'd0) ||
                  (sel_npkg_s > 32'd65535);
  end

  // Job sequencing; res_s/err_s are only meaningful on the transition into DONE.
  always_comb begin
    state_d    = state_q;
    id_d       = id_q;
    last_d     = last_q;
    total_d    = total_q;
    pkg_last_d = pkg_last_q;
    pkg_cnt_d  = pkg_cnt_q;
    phase_d    = phase_q;
    wdog_d     = wdog_q;
    res_s      = '0;
    err_s      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req0 | req1) begin
          id_d       = sel_s;
          last_d     = sel_s;
          total_d    = sel_total_s;
          pkg_last_d = sel_npkg_s[15:0] - 16'd1;
          if (sel_bad_s) begin
            err_s   = 1'b1;
            state_d = S_DONE;
          end else begin
            state_d = S_CLEAR;
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        pkg_cnt_d = 16'd0;
        phase_d   = 16'd0;
        wdog_d    = 32'd0;
        state_d   = S_STREAM;
      end
      S_STREAM: begin
        phase_d = (phase_q == PH_LAST) ? 16'd0 : phase_q + 16'd1;
        if (phase_q == 16'd0) begin
          if (pkg_cnt_q == pkg_last_q) begin
            state_d = S_WAIT;
          end else begin
            pkg_cnt_d = pkg_cnt_q + 16'd1;
          end
        end else begin
          state_d = S_STREAM;
        end
      end
      S_WAIT: begin
        if (eng_finish) begin
          res_s   = eng_result;
          state_d = S_DONE;
        end else if (wdog_q == WD_LAST) begin
          err_s   = 1'b1;
          state_d = S_DONE;
        end else begin
          wdog_d = wdog_q + 32'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered, decoded from the next state so they align with it.
  always_comb begin
    active_s       = (state_d == S_CLEAR) || (state_d == S_STREAM) || (state_d == S_WAIT);
    grant0_d       = active_s && (id_d == 1'b0);
    grant1_d       = active_s && (id_d == 1'b1);
    eng_reset_d    = (state_d == S_CLEAR);
    eng_read_now_d = (state_d == S_STREAM) && (phase_d == 16'd0);
    pkg_addr_d     = eng_read_now_d ? pkg_cnt_d : 16'd0;
    eng_total_d    = active_s ? total_d : 32'd0;
    result_valid_d = (state_d == S_DONE);
    result_d       = result_valid_d ? res_s : '0;
    err_d          = result_valid_d ? err_s : 1'b0;
    done_id_d      = result_valid_d ? id_d : 1'b0;
    busy_d         = (state_d != S_IDLE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q        <= S_IDLE;
      id_q           <= 1'b0;
      last_q         <= 1'b1;
      total_q        <= 32'd0;
      pkg_last_q     <= 16'd0;
      pkg_cnt_q      <= 16'd0;
      phase_q        <= 16'd0;
      wdog_q         <= 32'd0;
      grant0_q       <= 1'b0;
      grant1_q       <= 1'b0;
      pkg_addr_q     <= 16'd0;
      eng_read_now_q <= 1'b0;
      eng_total_q    <= 32'd0;
      eng_reset_q    <= 1'b0;
      result_q       <= '0;
      result_valid_q <= 1'b0;
      done_id_q      <= 1'b0;
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      state_q        <= state_d;
      id_q           <= id_d;
      last_q         <= last_d;
      total_q        <= total_d;
      pkg_last_q     <= pkg_last_d;
      pkg_cnt_q      <= pkg_cnt_d;
      phase_q        <= phase_d;
      wdog_q         <= wdog_d;
      grant0_q       <= grant0_d;
      grant1_q       <= grant1_d;
      pkg_addr_q     <= pkg_addr_d;
      eng_read_now_q <= eng_read_now_d;
      eng_total_q    <= eng_total_d;
      eng_reset_q    <= eng_reset_d;
      result_q       <= result_d;
      result_valid_q <= result_valid_d;
      done_id_q      <= done_id_d;
      err_q          <= err_d;
      busy_q         <= busy_d;
    end
  end

  assign grant0       = grant0_q;
  assign grant1       = grant1_q;
  assign pkg_addr     = pkg_addr_q;
  assign eng_read_now = eng_read_now_q;
  assign eng_total    = eng_total_q;
  assign eng_reset    = eng_reset_q;
  assign result       = result_q;
  assign result_valid = result_valid_q;
  assign done_id      = done_id_q;
  assign err          = err_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_dot_product_job_scheduler.sv
// Scoreboard bench: requesters push expected results, a monitor pops on
// result_valid; a behavioural engine model answers package strobes.
module tb_dot_product_job_scheduler;
  localparam int EW  = 32;
  localparam int NU  = 128;
  localparam int PI  = 2;
  localparam int TMO = 1024;
  localparam logic [31:0] NU32 = 32'd128;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [31:0]   total0 = 32'd0, total1 = 32'd0;
  logic          grant0, grant1, eng_read_now, eng_reset, result_valid, done_id, err, busy;
  logic [15:0]   pkg_addr;
  logic [31:0]   eng_total;
  logic          eng_finish;
  logic [EW-1:0] eng_result, result;

  always #5 clk = ~clk;

  dot_product_job_scheduler #(.ELEMENT_WIDTH(EW), .NO_OF_UNITS(NU), .PKG_INTERVAL(PI), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1), .total0(total0), .total1(total1),
    .grant0(grant0), .grant1(grant1), .pkg_addr(pkg_addr), .eng_read_now(eng_read_now),
    .eng_total(eng_total), .eng_reset(eng_reset), .eng_finish(eng_finish), .eng_result(eng_result),
    .result(result), .result_valid(result_valid), .done_id(done_id), .err(err), .busy(busy));

  typedef struct {
    logic          id;
    logic [EW-1:0] res;
    logic          err;
    int            npkg;
    bit            hang;
    int            lat;
  } exp_t;

  exp_t          exp_q[$];
  int            done_log[$];
  int            n_tests = 0, n_fail = 0, cyc = 0;
  logic [31:0]   plan_total[2];
  logic [EW-1:0] plan_val[2];
  int            plan_lat[2];
  bit            plan_hang[2];

  // engine model state
  logic          eng_fin_m = 1'b0, stray = 1'b0;
  logic [EW-1:0] eng_res_m = '0;
  int            strb_cnt = 0, fin_cnt = 0, prev_strb_cyc = 0, last_strb_cyc = 0;
  int            job_strobes = 0, rst_pulses = 0, eng_r = 0;

  assign eng_finish = eng_fin_m | stray;
  assign eng_result = eng_res_m;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Engine: counts strobes, raises sticky finish lat cycles after the last one.
  initial forever begin
    @(negedge clk);
    if (!reset) begin
      eng_fin_m = 1'b0; fin_cnt = 0; strb_cnt = 0; job_strobes = 0; rst_pulses = 0; stray = 1'b0;
    end else begin
      chk("grant_overlap", {63'd0, grant0 & grant1}, 64'd0);
      if (eng_reset) begin
        rst_pulses++; eng_fin_m = 1'b0; fin_cnt = 0; strb_cnt = 0;
      end
      if (eng_read_now) begin
        eng_r = grant1 ? 1 : 0;
        chk("strobe_has_grant", {63'd0, grant0 | grant1}, 64'd1);
        chk("pkg_addr", pkg_addr, strb_cnt);
        chk("eng_total", eng_total, plan_total[eng_r]);
        if (strb_cnt > 0) chk("strobe_gap", cyc - prev_strb_cyc, PI);
        prev_strb_cyc = cyc; strb_cnt++; job_strobes++; stray = 1'b0;
        if (strb_cnt == int'(eng_total / NU32)) begin
          last_strb_cyc = cyc;
          if (!plan_hang[eng_r]) begin
            fin_cnt = plan_lat[eng_r]; eng_res_m = plan_val[eng_r];
          end
        end
      end else if (fin_cnt > 0) begin
        fin_cnt--;
        if (fin_cnt == 0) eng_fin_m = 1'b1;
      end
    end
  end

  // Monitor: pop the matching expectation whenever a result is presented.
  initial forever begin
    int   found;
    exp_t e;
    @(negedge clk);
    if (reset && result_valid) begin
      found = -1;
      for (int i = 0; i < exp_q.size(); i++)
        if (found < 0 && exp_q[i].id == done_id) found = i;
      if (found < 0) begin
        n_tests++; n_fail++;
        $display("FAIL unexpected_result: got done_id %0d result 0x%0h, expected no result", done_id, result);
      end else begin
        e = exp_q[found];
        exp_q.delete(found);
        chk("result", result, e.res);
        chk("err", {63'd0, err}, {63'd0, e.err});
        chk("grant_low_in_done", {62'd0, grant0, grant1}, 64'd0);
        chk("busy_in_done", {63'd0, busy}, 64'd1);
        chk("eng_total_in_done", eng_total, 64'd0);
        chk("strobe_count", job_strobes, e.npkg);
        chk("eng_reset_pulses", rst_pulses, (e.npkg > 0) ? 1 : 0);
        if (e.npkg > 0)
          chk("result_latency", cyc - last_strb_cyc, e.hang ? TMO + 1 : e.lat + 1);
      end
      done_log.push_back(int'(done_id));
      job_strobes = 0; rst_pulses = 0;
    end
  end

  task automatic issue(input int r, input logic [31:0] tot, input logic [EW-1:0] val,
                       input int lat, input bit hang, input bit keep, output int took);
    exp_t e;
    int   t0;
    bit   got;
    e.id = r[0]; e.hang = hang; e.lat = lat;
    if (tot != 32'd0 && (tot % NU32) == 32'd0 && (tot / NU32) <= 32'd65535) begin
      e.npkg = int'(tot / NU32);
      e.res  = hang ? '0 : val;
      e.err  = hang;
    end else begin
      e.npkg = 0; e.res = '0; e.err = 1'b1;
    end
    plan_total[r] = tot; plan_val[r] = val; plan_lat[r] = lat; plan_hang[r] = hang;
    exp_q.push_back(e);
    if (r == 0) begin total0 = tot; req0 = 1'b1; end
    else begin total1 = tot; req1 = 1'b1; end
    t0 = cyc; got = 1'b0;
    for (int k = 0; k < 5000 && !got; k++) begin
      @(negedge clk);
      if (result_valid && done_id == r[0]) got = 1'b1;
    end
    took = cyc - t0;
    if (!got) begin
      n_tests++; n_fail++;
      $display("FAIL req%0d_no_result: got no result_valid in 5000 cycles, expected one", r);
    end
    if (!keep) begin
      if (r == 0) req0 = 1'b0; else req1 = 1'b0;
    end
  endtask

  task automatic rand_jobs(input int r, input int n);
    int          took;
    logic [31:0] tot;
    for (int j = 0; j < n; j++) begin
      case ($urandom_range(0, 7))
        0: tot = 32'd0;
        1: tot = 32'd128;
        2: tot = 32'd256;
        3: tot = 32'd384;
        4: tot = 32'd512;
        5: tot = 32'($urandom_range(1, 1000));
        6: tot = 32'(128 * $urandom_range(1, 6) + $urandom_range(1, 127));
        default: tot = ($urandom_range(0, 1) == 0) ? 32'h0080_0000 : 32'hFFFF_FF80;
      endcase
      issue(r, tot, $urandom, $urandom_range(1, 6), ($urandom_range(0, 15) == 0), 1'b0, took);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  initial begin
    #900000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int t0, t1;
    int exp_order[4] = '{0, 1, 0, 1};
    #2 reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_ctrl", {56'd0, grant0, grant1, eng_read_now, eng_reset, result_valid, err, busy, done_id}, 64'd0);
    chk("reset_pkg_addr", pkg_addr, 64'd0);
    chk("reset_eng_total", eng_total, 64'd0);
    chk("reset_result", result, 64'd0);
    reset = 1'b1;
    @(negedge clk);

    // tie from reset: 0, then 1, then 0 again with both re-requesting
    done_log.delete();
    fork
      begin issue(0, 32'd128, 32'h0000_1111, 2, 1'b0, 1'b1, t0); issue(0, 32'd128, 32'h0000_2222, 3, 1'b0, 1'b0, t0); end
      begin issue(1, 32'd128, 32'h0000_3333, 1, 1'b0, 1'b1, t1); issue(1, 32'd128, 32'h0000_4444, 2, 1'b0, 1'b0, t1); end
    join
    for (int i = 0; i < 4; i++)
      chk("rr_order", (i < done_log.size()) ? done_log[i] : 9, exp_order[i]);

    issue(0, 32'd256, 32'h3F80_0000, 4, 1'b0, 1'b0, t0);
    repeat (2) @(negedge clk);
    issue(1, 32'd200, 32'h5555_5555, 2, 1'b0, 1'b0, t0);
    chk("bad_len_within_3", {63'd0, (t0 <= 3)}, 64'd1);
    issue(0, 32'd128, 32'h6666_6666, 2, 1'b1, 1'b0, t0);

    stray = 1'b1; eng_res_m = 32'hDEAD_BEEF;
    repeat (3) @(negedge clk);
    issue(1, 32'd256, 32'h4049_0FDB, 3, 1'b0, 1'b0, t0);

    // abort a 512-element job in STREAM with the reset pin
    plan_total[0] = 32'd512; plan_val[0] = 32'h1234_5678; plan_lat[0] = 3; plan_hang[0] = 1'b0;
    total0 = 32'd512; req0 = 1'b1;
    for (int k = 0; k < 60 && job_strobes < 2; k++) @(negedge clk);
    chk("abort_in_stream", job_strobes, 2);
    #2 reset = 1'b0;
    #1;
    chk("abort_ctrl", {56'd0, grant0, grant1, eng_read_now, eng_reset, result_valid, err, busy, done_id}, 64'd0);
    chk("abort_eng_total", eng_total, 64'd0);
    chk("abort_pkg_addr", pkg_addr, 64'd0);
    req0 = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    issue(0, 32'd256, 32'h7777_0001, 2, 1'b0, 1'b0, t0);

    fork
      rand_jobs(0, 12);
      rand_jobs(1, 12);
    join
    repeat (5) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/dot_product_job_scheduler.md
DOT_PRODUCT_JOB_SCHEDULER -- requirements
Module: dot_product_job_scheduler

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  ELEMENT_WIDTH, 32, element/result width
  NO_OF_UNITS, 128, elements per package
  PKG_INTERVAL, 2, cycles between package issues (engine processes each package as two halves)
  TIMEOUT, 1024, max WAIT cycles before abort
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk  in  1  sole clock, rising edge
  reset  in  1  asynchronous, active-low; reset=0 forces reset state immediately
  req0, req1  in  1  job request from requester 0/1, level, held until own result_valid
  total0, total1  in  32  element count of requester's job, stable while req high
  grant0, grant1  out  1  requester owns engine and package stream
  pkg_addr  out  16  package index requested from owning requester's buffer
  eng_read_now  out  1  one-cycle package strobe to engine, coincident with pkg_addr
  eng_total  out  32  latched total driven to engine
  eng_reset  out  1  active-high synchronous clear of engine
  eng_finish  in  1  engine result valid, sticky until eng_reset
  eng_result  in  ELEMENT_WIDTH  engine dot-product result
  result  out  ELEMENT_WIDTH  job result
  result_valid  out  1  one-cycle pulse
  done_id  out  1  requester index for result, valid with result_valid
  err  out  1  one-cycle pulse with result_valid on bad length or timeout
  busy  out  1  high in every state except IDLE

Function
REQ-003 FSM states: IDLE, CLEAR, STREAM, WAIT, DONE.
REQ-004 IDLE: on any req, select requester round-robin (priority to the requester not served last; after reset requester 0 wins ties); latch total and id; assert grant next cycle; go CLEAR.
REQ-005 Length check at selection: total==0 or total not a multiple of NO_OF_UNITS -> skip engine, go DONE with result=0, err=1.
REQ-006 CLEAR: eng_reset=1 for exactly one cycle; pkg counter=0; go STREAM.
REQ-007 STREAM: eng_read_now pulses once every PKG_INTERVAL cycles, first pulse on the first STREAM cycle; pkg_addr = 0,1,..,total/NO_OF_UNITS-1 in order; after last pulse go WAIT.
REQ-008 WAIT: engine finish observed in the cycle eng_finish=1 -> capture eng_result into result, go DONE; watchdog counts WAIT cycles, reaching TIMEOUT -> result=0, err=1, go DONE.
REQ-009 DONE: result_valid=1, done_id=latched id, err per REQ-005/REQ-008, for one cycle; grant deasserted same cycle; next state IDLE.
REQ-010 grant0/grant1 are one-hot or zero; a grant is high from the cycle after selection through DONE inclusive of the last STREAM/WAIT cycle, low in DONE.
REQ-011 req deassertion mid-job is ignored; job runs to DONE. New requests are not sampled outside IDLE.
REQ-012 Simultaneous req0 and req1 in IDLE resolved per REQ-004; loser stays pending and is served next from IDLE with no idle cycle beyond DONE->IDLE.
REQ-013 eng_total holds latched total from CLEAR through WAIT; 0 otherwise.
REQ-014 eng_finish asserted outside WAIT is ignored.
REQ-015 Package counter 16 bits; total/NO_OF_UNITS > 65535 treated as bad length (REQ-005).

Reset
REQ-016 While reset=0: state IDLE, all outputs 0 (grant0, grant1, eng_read_now, eng_reset, result_valid, err, busy, pkg_addr, eng_total, result, done_id), round-robin pointer favours requester 0.
REQ-017 reset asserted mid-job aborts immediately with no result_valid; after release the engine is re-cleared by the next CLEAR before reuse.

Verification
REQ-018 req0=1, total0=256, engine model returns 0x3F800000 4 cycles after 2nd strobe -> grant0, eng_reset 1 cycle, strobes with pkg_addr 0,1 two cycles apart, result=0x3F800000, done_id=0, err=0.
REQ-019 req0=req1=1 from reset, total=128 each -> requester 0 served, then requester 1, then with both re-requesting requester 0 again; grants never overlap.
REQ-020 req1=1, total1=200 -> no eng_read_now, result_valid with result=0, err=1, done_id=1, within 3 cycles of request.
REQ-021 total0=128, engine never asserts eng_finish -> err=1, result=0 exactly TIMEOUT cycles after entering WAIT.
REQ-022 reset pulled low during STREAM of a 512-element job -> outputs 0 asynchronously, no result_valid; next job completes normally.
REQ-023 eng_finish=1 held high while IDLE and during CLEAR -> ignored; result taken only from WAIT.
